// File: rtl/async_fifo_rd_packer.sv
// Read-side drain of an async FIFO: packs PACK consecutive DSIZE-bit words into one valid/ready beat.
// Optional `RD_PACK_STATS_EN adds saturating word-pop and stall counters.
module async_fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic [DSIZE*PACK-1:0] out_data,
    output logic [PACK-1:0]       out_keep,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef RD_PACK_STATS_EN
    ,
    output logic [15:0]           stat_words,
    output logic [15:0]           stat_stall
`endif
);

    // Handshake: a beat moves on any rclk edge where out_valid & out_ready; the
    // beat is held unchanged until then. rinc pops the FIFO head in the same cycle.
    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DSIZE*PACK-1:0] acc_q, acc_d;
    logic [DSIZE*PACK-1:0] out_data_q, out_data_d;
    logic [PACK-1:0]       out_keep_q, out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic                  pend_q, pend_d;

    logic                  out_free;
    logic                  flush_req;
    logic                  pop;
    logic                  full_load;
    logic                  flush_go;
    logic                  load;
    logic [CW-1:0]         n_fill;
    logic [DSIZE*PACK-1:0] acc_new;
    logic [PACK-1:0]       keep_new;

    always_comb begin
        out_free  = !out_valid_q | out_ready;
        flush_req = flush | pend_q;
        pop       = !rrst & !rempty & !pend_q & ((cnt_q < LAST) | out_free);

        acc_new = acc_q;
        for (int i = 0; i < PACK; i++) begin
            if (pop && (CW'(i) == cnt_q)) begin
                acc_new[i*DSIZE +: DSIZE] = rdata;
            end
        end
        n_fill = cnt_q + CW'(pop);

        keep_new = '0;
        for (int i = 0; i < PACK; i++) begin
            keep_new[i] = (CW'(i) < n_fill);
        end

        full_load = pop & (cnt_q == LAST);
        flush_go  = flush_req & out_free & (n_fill != '0) & !full_load;
        load      = full_load | flush_go;

        // Lanes above cnt are kept zero, so the accumulator can load the output directly.
        cnt_d       = load ? '0 : n_fill;
        acc_d       = load ? '0 : acc_new;
        out_valid_d = load | (out_valid_q & !out_ready);
        out_data_d  = load ? acc_new : out_data_q;
        out_keep_d  = load ? keep_new : out_keep_q;
        pend_d      = flush_req & !out_free;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            pend_q      <= pend_d;
        end
    end

    assign rinc      = pop;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;

`ifdef RD_PACK_STATS_EN
    logic [15:0] words_q, words_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        words_d = words_q;
        stall_d = stall_q;
        if (pop && (words_q != 16'hFFFF)) begin
            words_d = words_q + 16'd1;
        end
        if (!rempty && !pop && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign stat_words = words_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Bench for async_fifo_rd_packer (DSIZE=8, PACK=4) with a behavioural FIFO and a beat scoreboard.
// Inputs change 1 ns after posedge; transfers and pops are observed on negedge.
module tb_async_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
`ifdef RD_PACK_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stall;
`endif

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int words_cnt = 0;
    int stall_cnt = 0;

    logic [35:0] exp_q[$];

    logic [7:0] mem[0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr];

    async_fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RD_PACK_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_stall(stat_stall)
`endif
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 8'd1;
    end

    // Scoreboard and event counters, sampled mid-cycle.
    always @(negedge rclk) begin
        if (rrst) begin
            words_cnt = 0;
            stall_cnt = 0;
        end else begin
            if (rinc) words_cnt++;
            if (!rempty && !rinc) stall_cnt++;
        end
        if (rinc) pop_cnt++;
        if (!rrst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got keep=%h data=%h, required none", out_keep, out_data);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({out_keep, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat_compare: got keep=%h data=%h, required keep=%h data=%h",
                             out_keep, out_data, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_pops(input int target, input string name);
        int n;
        n = 0;
        while (pop_cnt < target && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (pop_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: got pops=%0d, required %0d", name, pop_cnt, target);
        end
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_keep, out_data, rinc} !== 38'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b keep=%h data=%h rinc=%b, required all 0",
                     out_valid, out_keep, out_data, rinc);
        end
        rrst = 1'b0;
        tick();
    endtask

    task automatic test_full_beat();
        int base;
        base = pop_cnt;
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        exp_q.push_back({4'hF, 32'h44332211});
        wait_pops(base + 4, "full_beat");
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_keep !== 4'hF) begin
            errors++;
            $display("FAIL full_beat_latency: got valid=%b keep=%h data=%h, required 1 F 44332211",
                     out_valid, out_keep, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || pop_cnt != base + 4) begin
            errors++;
            $display("FAIL full_beat_pulse: got valid=%b pops=%0d, required 0 %0d",
                     out_valid, pop_cnt - base, 4);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        exp_q.push_back({4'hF, 32'hA3A2A1A0});
        exp_q.push_back({4'hF, 32'hA7A6A5A4});
        repeat (20) tick();
        checks++;
        if (pop_cnt - base != 7 || out_data !== 32'hA3A2A1A0 || out_valid !== 1'b1 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got pops=%0d data=%h valid=%b rinc=%b, required 7 A3A2A1A0 1 0",
                     pop_cnt - base, out_data, out_valid, rinc);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA7A6A5A4 || out_keep !== 4'hF) begin
            errors++;
            $display("FAIL back_to_back: got valid=%b keep=%h data=%h, required 1 F A7A6A5A4",
                     out_valid, out_keep, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_drain: got valid=%b, required 0", out_valid);
        end
`ifdef RD_PACK_STATS_EN
        checks++;
        if (stat_words !== 16'd8 || stat_words !== 16'(words_cnt)) begin
            errors++;
            $display("FAIL stat_words: got %0d, required 8", stat_words);
        end
        checks++;
        if (stat_stall !== 16'(stall_cnt) || stall_cnt < 10) begin
            errors++;
            $display("FAIL stat_stall: got %0d, required %0d", stat_stall, stall_cnt);
        end
`endif
    endtask

    task automatic test_flush();
        int base;
        base = pop_cnt;
        out_ready = 1'b1;
        push(8'h05); push(8'h06);
        exp_q.push_back({4'h3, 32'h00000605});
        wait_pops(base + 2, "flush");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000605 || out_keep !== 4'h3) begin
            errors++;
            $display("FAIL flush_partial: got valid=%b keep=%h data=%h, required 1 3 00000605",
                     out_valid, out_keep, out_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_ignored: got valid=%b, required 0", out_valid);
        end

        // Flush while the output is occupied stays pending and blocks pops.
        base = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        exp_q.push_back({4'hF, 32'hD3D2D1D0});
        exp_q.push_back({4'h3, 32'h0000D5D4});
        exp_q.push_back({4'h1, 32'h000000D6});
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(8'hD6);
        repeat (3) tick();
        checks++;
        if (pop_cnt - base != 6 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending_block: got pops=%0d rinc=%b, required 6 0", pop_cnt - base, rinc);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000D5D4 || out_keep !== 4'h3) begin
            errors++;
            $display("FAIL flush_pending_exec: got valid=%b keep=%h data=%h, required 1 3 0000D5D4",
                     out_valid, out_keep, out_data);
        end
        wait_pops(base + 7, "flush_after_pending");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int base;
        base = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
        repeat (10) tick();
        checks++;
        if (pop_cnt - base != 6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got pops=%0d valid=%b, required 6 1", pop_cnt - base, out_valid);
        end
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        rrst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_rinc: got rinc=%b, required 0", rinc);
        end
        base = pop_cnt;
        tick();
        rrst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_keep !== 4'h0 || pop_cnt != base) begin
            errors++;
            $display("FAIL reset_mid_clear: got valid=%b keep=%h pops=%0d, required 0 0 0",
                     out_valid, out_keep, pop_cnt - base);
        end
        out_ready = 1'b1;
        exp_q.push_back({4'hF, 32'hC3C2C1C0});
        wait_pops(base + 4, "reset_mid");
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC3C2C1C0) begin
            errors++;
            $display("FAIL reset_mid_fresh: got valid=%b data=%h, required 1 C3C2C1C0", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_flush_with_pop();
        int base;
        base = pop_cnt;
        out_ready = 1'b1;
        push(8'h07); push(8'h08);
        exp_q.push_back({4'h7, 32'h00090807});
        wait_pops(base + 2, "flush_with_pop");
        push(8'h09);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00090807 || out_keep !== 4'h7) begin
            errors++;
            $display("FAIL flush_with_pop: got valid=%b keep=%h data=%h, required 1 7 00090807",
                     out_valid, out_keep, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 6; b++) begin
            logic [31:0] beat;
            for (int i = 0; i < 4; i++) begin
                beat[i*8 +: 8] = 8'($urandom_range(0, 255));
                push(beat[i*8 +: 8]);
            end
            exp_q.push_back({4'hF, beat});
        end
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_flush_with_pop();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
